// File: rtl/tmds_link_sequencer.sv
// TMDS link sequencer: brings the serializer out of reset after the PLL has settled,
// sends blanking control tokens, then forwards encoder words. It falls back to a safe
// state (serializer held in reset, control tokens) on PLL lock loss or host disable.
module tmds_link_sequencer #(
    parameter int NUM_CHANNELS       = 3,
    parameter int LOCK_SETTLE_CYCLES = 1024,
    parameter int SER_RESET_CYCLES   = 16,
    parameter int BLANK_CYCLES       = 128
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       enable,
    input  logic       pll_locked,
    input  logic [9:0] tmds_in [NUM_CHANNELS-1:0],
    output logic [9:0] tmds_out [NUM_CHANNELS-1:0],
    output logic       serializer_reset,
    output logic       link_up,
    output logic [2:0] state
);

    // Blanking control token, C1C0 = 00
    localparam logic [9:0] CTRL = 10'b1101010100;

    localparam int MAX_AB     = (LOCK_SETTLE_CYCLES > SER_RESET_CYCLES) ? LOCK_SETTLE_CYCLES : SER_RESET_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > BLANK_CYCLES) ? MAX_AB : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // The counter is loaded with N-1 on entry and the state exits when it reads zero,
    // so each timed state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(LOCK_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SERRST_LOAD = CNT_W'(SER_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD  = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_LOCK   = 3'd1,
        LOCK_SETTLE = 3'd2,
        SER_RESET   = 3'd3,
        BLANK       = 3'd4,
        ACTIVE      = 3'd5,
        QUIESCE     = 3'd6
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_done;
    logic             ser_reset_d;
    logic             link_up_d;

    assign cnt_done = (cnt_q == '0);
    assign state    = state_q;

    // State, counter and all outputs are registered; outputs follow the next state
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            serializer_reset <= 1'b1;
            link_up          <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                tmds_out[c] <= CTRL;
            end
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            serializer_reset <= ser_reset_d;
            link_up          <= link_up_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                tmds_out[c] <= link_up_d ? tmds_in[c] : CTRL;
            end
        end
    end

    // Next-state and shared down-counter; disable beats lock loss, lock loss beats timing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (!enable)        state_d = IDLE;
                else if (pll_locked) state_d = LOCK_SETTLE;
            end
            LOCK_SETTLE: begin
                if (!enable)          state_d = IDLE;
                else if (!pll_locked) state_d = WAIT_LOCK;
                else if (cnt_done)    state_d = SER_RESET;
            end
            SER_RESET: begin
                if (!enable)          state_d = IDLE;
                else if (!pll_locked) state_d = WAIT_LOCK;
                else if (cnt_done)    state_d = BLANK;
            end
            BLANK: begin
                if (!enable)          state_d = IDLE;
                else if (!pll_locked) state_d = WAIT_LOCK;
                else if (cnt_done)    state_d = ACTIVE;
            end
            ACTIVE: begin
                // A clean disable drains through QUIESCE; losing lock at the same time cannot.
                if (!enable)          state_d = pll_locked ? QUIESCE : IDLE;
                else if (!pll_locked) state_d = WAIT_LOCK;
            end
            QUIESCE: begin
                // Re-enable is ignored here; only lock loss cuts the shutdown short.
                if (!pll_locked)   state_d = enable ? WAIT_LOCK : IDLE;
                else if (cnt_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            unique case (state_d)
                LOCK_SETTLE: cnt_d = SETTLE_LOAD;
                SER_RESET:   cnt_d = SERRST_LOAD;
                BLANK:       cnt_d = BLANK_LOAD;
                QUIESCE:     cnt_d = BLANK_LOAD;
                default:     cnt_d = cnt_q;
            endcase
        end else if (!cnt_done) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Output decode from the next state so outputs change on the same edge as state
    always_comb begin
        ser_reset_d = 1'b1;
        link_up_d   = 1'b0;
        unique case (state_d)
            BLANK, QUIESCE: ser_reset_d = 1'b0;
            ACTIVE: begin
                ser_reset_d = 1'b0;
                link_up_d   = 1'b1;
            end
            default: ser_reset_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Bench for tmds_link_sequencer: directed bring-up / glitch / shutdown / reset scenarios
// followed by randomized control and data, scored against a cycle-level reference model.
module tb_tmds_link_sequencer;

    localparam int NCH = 3;
    localparam int LS  = 4;
    localparam int SR  = 2;
    localparam int BL  = 3;
    localparam logic [9:0] CTRL = 10'b1101010100;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic       enable;
    logic       pll_locked;
    logic [9:0] tmds_in  [NCH-1:0];
    logic [9:0] tmds_out [NCH-1:0];
    logic       serializer_reset;
    logic       link_up;
    logic [2:0] state;

    tmds_link_sequencer #(
        .NUM_CHANNELS      (NCH),
        .LOCK_SETTLE_CYCLES(LS),
        .SER_RESET_CYCLES  (SR),
        .BLANK_CYCLES      (BL)
    ) dut (
        .clk_pixel       (clk_pixel),
        .reset           (reset),
        .enable          (enable),
        .pll_locked      (pll_locked),
        .tmds_in         (tmds_in),
        .tmds_out        (tmds_out),
        .serializer_reset(serializer_reset),
        .link_up         (link_up),
        .state           (state)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct packed {
        logic [2:0]       st;
        logic             sr;
        logic             lu;
        logic [NCH*10-1:0] data;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   fixed_pat  = 1'b0;

    // Reference model: current phase and how many cycles it has lasted so far
    int m_phase = 0;
    int m_age   = 0;

    function automatic int phase_len(input int p);
        case (p)
            2:       return LS;
            3:       return SR;
            4:       return BL;
            6:       return BL;
            default: return 0;
        endcase
    endfunction

    function automatic int phase_after(input int p);
        case (p)
            2:       return 3;
            3:       return 4;
            4:       return 5;
            default: return 0;
        endcase
    endfunction

    // Apply one cycle of inputs, predict what the next edge produces, then wait a cycle
    task automatic step(input bit r, input bit e, input bit l);
        exp_t x;
        int   nxt;
        reset      = r;
        enable     = e;
        pll_locked = l;
        for (int c = 0; c < NCH; c++) begin
            if (fixed_pat) tmds_in[c] = (c == 0) ? 10'h2AA : (c == 1) ? 10'h155 : 10'h3FF;
            else           tmds_in[c] = 10'($urandom);
        end

        if (r) begin
            nxt = 0;
        end else if (m_phase == 5) begin
            if (!e)      nxt = l ? 6 : 0;
            else if (!l) nxt = 1;
            else         nxt = 5;
        end else if (m_phase >= 1 && m_phase <= 4 && !e) begin
            nxt = 0;
        end else if ((m_phase >= 2 && m_phase <= 4 || m_phase == 6) && !l) begin
            nxt = e ? 1 : 0;
        end else if (m_phase == 0) begin
            nxt = e ? 1 : 0;
        end else if (m_phase == 1) begin
            nxt = l ? 2 : 1;
        end else if (m_age + 1 >= phase_len(m_phase)) begin
            nxt = phase_after(m_phase);
        end else begin
            nxt = m_phase;
        end

        m_age   = (!r && nxt == m_phase) ? m_age + 1 : 0;
        m_phase = nxt;

        x.st = 3'(nxt);
        x.sr = (nxt <= 3);
        x.lu = (nxt == 5);
        for (int c = 0; c < NCH; c++) begin
            x.data[c*10 +: 10] = (nxt == 5) ? tmds_in[c] : CTRL;
        end
        q.push_back(x);
        @(negedge clk_pixel);
    endtask

    // Monitor: one registered response per clock edge, compared against the queue head
    initial begin
        exp_t x;
        forever begin
            @(posedge clk_pixel);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                compared++;
                if (state !== x.st) begin
                    mismatched++;
                    $display("FAIL state: got %0d expected %0d at %0t", state, x.st, $time);
                end
                compared++;
                if (serializer_reset !== x.sr) begin
                    mismatched++;
                    $display("FAIL serializer_reset: got %b expected %b at %0t", serializer_reset, x.sr, $time);
                end
                compared++;
                if (link_up !== x.lu) begin
                    mismatched++;
                    $display("FAIL link_up: got %b expected %b at %0t", link_up, x.lu, $time);
                end
                for (int c = 0; c < NCH; c++) begin
                    compared++;
                    if (tmds_out[c] !== x.data[c*10 +: 10]) begin
                        mismatched++;
                        $display("FAIL tmds_out[%0d]: got %h expected %h at %0t", c, tmds_out[c], x.data[c*10 +: 10], $time);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        // Reset, then bring-up with enable and lock held
        repeat (2) step(1, 0, 0);
        repeat (12) step(0, 1, 1);

        // Passthrough of a known pattern while active
        fixed_pat = 1'b1;
        repeat (4) step(0, 1, 1);
        fixed_pat = 1'b0;
        repeat (4) step(0, 1, 1);

        // Graceful disable with an enable pulse during QUIESCE
        step(0, 0, 1);
        step(0, 1, 1);
        repeat (4) step(0, 0, 1);

        // Lock glitch in the third LOCK_SETTLE cycle, then full bring-up
        repeat (4) step(0, 1, 1);
        step(0, 1, 0);
        repeat (12) step(0, 1, 1);

        // Simultaneous disable and lock loss while active
        step(0, 0, 0);
        step(0, 0, 1);

        // Mid-operation reset in BLANK, then in ACTIVE
        repeat (8) step(0, 1, 1);
        step(1, 1, 1);
        repeat (12) step(0, 1, 1);
        step(1, 1, 1);
        step(0, 0, 1);

        // Randomized control and data
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 200) == 0, ($urandom % 40) != 0, ($urandom % 60) != 0);
        end

        repeat (2) @(posedge clk_pixel);
        #2;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
